// File: rtl/serial_slave_port_if.sv
// Serial slave port bus: bit-serial header/data lines from the master,
// serial read data and a per-cycle ready/stall indication from the slave.
interface serial_slave_port_if;
    logic control;
    logic wD;
    logic valid;
    logic last;
    logic rD;
    logic ready;

    modport master (
        output control,
        output wD,
        output valid,
        output last,
        input  rD,
        input  ready
    );

    modport slave (
        input  control,
        input  wD,
        input  valid,
        input  last,
        output rD,
        output ready
    );
endinterface

// File: rtl/serial_slave_port.sv
// Bit-serial slave port in front of a small word memory.
// A transaction is a start bit, a direction bit and an MSB-first address on
// 'control', followed by a burst of MSB-first data words that auto-increment
// the address. Writes land in memory on the edge that completes a word; reads
// spend one stall cycle fetching each word before shifting it out on rD.
module serial_slave_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_slave_port_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MAX_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    // One counter serves both the address header and the data bits, so it is
    // sized for whichever is longer; it never counts past MAX_W-1.
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RW,
        HDR_ADDR,
        WRITE,
        RD_FETCH,
        RD_SHIFT
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    dir_reg, dir_next;
    logic [DATA_WIDTH-1:0]   wr_word_reg, wr_word_next;
    logic [DATA_WIDTH-1:0]   wr_shifted;
    logic [DATA_WIDTH-1:0]   rd_word_reg;
    logic [DATA_WIDTH-1:0]   rd_sel;
    logic                    rd_bit;
    logic                    mem_we;
    logic                    last_data_bit;
    logic                    last_addr_bit;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    // Word register with the incoming bit appended; this is also the memory
    // write data so the final bit reaches memory on the same edge.
    assign wr_shifted    = (wr_word_reg << 1) | DATA_WIDTH'(bus.wD);
    assign last_data_bit = (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1));
    assign last_addr_bit = (bit_cnt_reg == CNT_W'(ADDR_WIDTH - 1));

    // Select the read bit addressed by the counter, MSB first: one AND term
    // per word bit, OR-reduced.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rd_sel
            assign rd_sel[gi] = rd_word_reg[gi] &
                                (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1 - gi));
        end
    endgenerate
    assign rd_bit = |rd_sel;

    assign bus.rD = (state_reg == RD_SHIFT) ? rd_bit : 1'b0;

    // Next-state, counter, address and memory-write decode.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        addr_next    = addr_reg;
        dir_next     = dir_reg;
        wr_word_next = wr_word_reg;
        mem_we       = 1'b0;
        bus.ready    = 1'b1;

        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                if (bus.control) begin
                    state_next = HDR_RW;
                end
            end

            HDR_RW: begin
                dir_next     = bus.control;
                bit_cnt_next = '0;
                state_next   = HDR_ADDR;
            end

            HDR_ADDR: begin
                // Shifting in ADDR_WIDTH bits fully replaces the old address.
                addr_next = (addr_reg << 1) | ADDR_WIDTH'(bus.control);
                if (last_addr_bit) begin
                    bit_cnt_next = '0;
                    wr_word_next = '0;
                    state_next   = dir_reg ? WRITE : RD_FETCH;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end

            WRITE: begin
                if (bus.valid) begin
                    wr_word_next = wr_shifted;
                    if (last_data_bit) begin
                        mem_we       = 1'b1;
                        addr_next    = addr_reg + ADDR_WIDTH'(1);
                        bit_cnt_next = '0;
                        if (bus.last) begin
                            state_next = IDLE;
                        end
                    end else if (bus.last) begin
                        // Burst ended mid-word: the partial word is dropped.
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end

            RD_FETCH: begin
                bus.ready    = 1'b0;
                bit_cnt_next = '0;
                state_next   = RD_SHIFT;
            end

            RD_SHIFT: begin
                if (bus.valid) begin
                    if (last_data_bit) begin
                        addr_next    = addr_reg + ADDR_WIDTH'(1);
                        bit_cnt_next = '0;
                        state_next   = bus.last ? IDLE : RD_FETCH;
                    end else if (bus.last) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Control state registers; reset returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            addr_reg    <= '0;
            dir_reg     <= 1'b0;
            wr_word_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            addr_reg    <= addr_next;
            dir_reg     <= dir_next;
            wr_word_reg <= wr_word_next;
        end
    end

    // Word memory (not reset) with a registered read that is loaded during
    // the fetch stall; the address cannot move while the word is shifted out.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_reg] <= wr_shifted;
        end
        if (state_reg == RD_FETCH) begin
            rd_word_reg <= mem[addr_reg];
        end
    end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port. Read tasks push the expected rD bit
// stream into a queue; an independent monitor compares rD against the queue
// head whenever the slave presents read data and pops on each consumed bit.
module tb_serial_slave_port;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    logic rd_active;
    logic exp_q[$];

    serial_slave_port_if bus ();

    serial_slave_port #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Read-data monitor: checks the held bit during gaps, pops on consumption.
    always @(negedge clk) begin
        if (rd_active && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rd_extra: got rD=%0b with ready=1, required no more read data", bus.rD);
            end else begin
                check("rd_bit", {31'd0, bus.rD}, {31'd0, exp_q[0]});
                if (bus.valid) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.control = 1'b0;
        bus.valid   = 1'b0;
        bus.wD      = 1'b0;
        bus.last    = 1'b0;
    endtask

    task automatic send_header(input logic dir, input logic [3:0] a);
        bus.control = 1'b1;
        tick();
        bus.control = dir;
        tick();
        for (int i = 3; i >= 0; i--) begin
            bus.control = a[i];
            tick();
        end
        bus.control = 1'b0;
    endtask

    // nbits MSB-first from data[nbits-1:0], last on the final bit.
    task automatic write_bits(input logic [3:0] a, input logic [15:0] data,
                              input int nbits, input logic gaps);
        send_header(1'b1, a);
        for (int b = 0; b < nbits; b++) begin
            if (gaps && (b == 2 || b == 6)) begin
                bus.valid = 1'b0;
                bus.wD    = 1'b1;
                bus.last  = 1'b1;
                tick();
            end
            bus.valid   = 1'b1;
            bus.wD      = data[nbits-1-b];
            bus.last    = (b == nbits - 1);
            bus.control = b[0];
            tick();
        end
        idle_bus();
        check("wr_done_ready", {31'd0, bus.ready}, 32'd1);
        $display("write addr=%0h bits=%0d data=%0h gaps=%0b", a, nbits, data, gaps);
    endtask

    // Reads nwords words; the final word is cut after stop_bit bits.
    task automatic read_words(input logic [3:0] a, input logic [7:0] w0, input logic [7:0] w1,
                              input int nwords, input int stop_bit, input logic gaps);
        logic [7:0] w;
        int nb;
        send_header(1'b0, a);
        check("fetch_ready", {31'd0, bus.ready}, 32'd0);
        for (int k = 0; k < nwords; k++) begin
            w  = (k == 0) ? w0 : w1;
            nb = (k == nwords - 1) ? stop_bit : 8;
            for (int b = 0; b < nb; b++) begin
                exp_q.push_back(w[7-b]);
            end
            rd_active = 1'b1;
            bus.valid = 1'b0;
            bus.last  = 1'b0;
            tick();
            for (int b = 0; b < nb; b++) begin
                if (gaps && (b == 2 || b == 6)) begin
                    bus.valid = 1'b0;
                    bus.last  = 1'b1;
                    tick();
                end
                bus.valid   = 1'b1;
                bus.last    = (k == nwords - 1) && (b == nb - 1);
                bus.control = ~b[0];
                tick();
            end
            idle_bus();
            if (k < nwords - 1) begin
                check("refetch_ready", {31'd0, bus.ready}, 32'd0);
            end
        end
        rd_active = 1'b0;
        check("rd_done_ready", {31'd0, bus.ready}, 32'd1);
        check("rd_done_rD", {31'd0, bus.rD}, 32'd0);
        check("rd_queue_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        $display("read  addr=%0h words=%0d stop_bit=%0d gaps=%0b", a, nwords, stop_bit, gaps);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rd_active = 1'b0;
        rst       = 1'b1;
        idle_bus();
        repeat (3) tick();
        rst = 1'b0;
        check("reset_ready", {31'd0, bus.ready}, 32'd1);
        check("reset_rD", {31'd0, bus.rD}, 32'd0);

        // Single write and read-back of addr 3.
        write_bits(4'h3, 16'h00A5, 8, 1'b0);
        read_words(4'h3, 8'hA5, 8'h00, 1, 8, 1'b0);

        // Wrapping burst write at addr 15, read back as a wrapping burst too.
        write_bits(4'hF, 16'h1122, 16, 1'b0);
        read_words(4'hF, 8'h11, 8'h22, 2, 8, 1'b0);
        read_words(4'h0, 8'h22, 8'h00, 1, 8, 1'b0);

        // Valid gaps on both directions.
        write_bits(4'h5, 16'h003C, 8, 1'b1);
        read_words(4'h5, 8'h3C, 8'h00, 1, 8, 1'b1);

        // Early last discards the partial word; next start bit accepted.
        write_bits(4'h7, 16'h005A, 8, 1'b0);
        write_bits(4'h7, 16'h001F, 5, 1'b0);
        read_words(4'h7, 8'h5A, 8'h00, 1, 8, 1'b0);

        // Aborted read, then a normal read still works.
        read_words(4'h3, 8'hA5, 8'h00, 1, 3, 1'b0);
        read_words(4'h5, 8'h3C, 8'h00, 1, 8, 1'b0);

        // Reset in the middle of a write word to addr 2.
        write_bits(4'h2, 16'h0077, 8, 1'b0);
        send_header(1'b1, 4'h2);
        for (int b = 0; b < 4; b++) begin
            bus.valid = 1'b1;
            bus.wD    = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_bus();
        check("midwrite_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("midwrite_rst_rD", {31'd0, bus.rD}, 32'd0);
        $display("reset during write data to addr 2");
        read_words(4'h2, 8'h77, 8'h00, 1, 8, 1'b0);
        read_words(4'h3, 8'hA5, 8'h00, 1, 8, 1'b0);

        // Reset in the middle of the address header, read starts right after.
        bus.control = 1'b1;
        tick();
        tick();
        bus.control = 1'b0;
        tick();
        bus.control = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.control = 1'b0;
        check("midhdr_rst_ready", {31'd0, bus.ready}, 32'd1);
        $display("reset during address header");
        read_words(4'h5, 8'h3C, 8'h00, 1, 8, 1'b1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_slave_port.md
SERIAL_SLAVE_PORT -- requirements
Module: serial_slave_port

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8: bits per data word.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 4: word-address bits; internal memory depth = 2**ADDR_WIDTH words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 control  input  1  serial header line: start bit, R/W bit, then address MSB first.
REQ-006 wD  input  1  serial write data, MSB first, qualified by valid.
REQ-007 valid  input  1  bit-strobe from master: write bit present (write) / read bit consumed (read).
REQ-008 last  input  1  end-of-burst marker, sampled only with valid=1.
REQ-009 rD  output  1  serial read data, MSB first; meaningful only in RD_SHIFT.
REQ-010 ready  output  1  1 = slave can accept/present a bit this cycle; 0 = stall.

Function
REQ-011 States SHALL be IDLE, HDR_RW, HDR_ADDR, WRITE, RD_FETCH, RD_SHIFT.
REQ-012 IDLE: control=1 -> HDR_RW; otherwise stay; valid/wD/last ignored.
REQ-013 HDR_RW: control sampled as direction (1=write, 0=read) -> HDR_ADDR; takes exactly 1 cycle.
REQ-014 HDR_ADDR: one address bit per cycle, MSB first, exactly ADDR_WIDTH cycles, valid not required; then WRITE (write) or RD_FETCH (read).
REQ-015 control SHALL be ignored in every state except IDLE, HDR_RW, HDR_ADDR.
REQ-016 WRITE: each cycle with valid=1 shifts wD into the word register; valid=0 holds all state.
REQ-017 On the DATA_WIDTH-th valid bit, the assembled word (including that bit) SHALL be written to mem[addr] at that same clock edge; addr increments modulo 2**ADDR_WIDTH; bit counter clears.
REQ-018 last=1 on the final bit of a word: word written, then -> IDLE.
REQ-019 last=1 on any other bit: partial word discarded, no memory write, -> IDLE.
REQ-020 RD_FETCH: ready=0 for exactly 1 cycle; mem[addr] loaded into read shift register -> RD_SHIFT.
REQ-021 RD_SHIFT: rD = current MSB of read shift register; ready=1; each valid=1 cycle advances one bit; valid=0 holds rD.
REQ-022 On the DATA_WIDTH-th consumed bit: addr increments modulo 2**ADDR_WIDTH; last=1 -> IDLE, else -> RD_FETCH.
REQ-023 last=1 on a non-final read bit SHALL abort the read -> IDLE.
REQ-024 ready SHALL be 1 in all states except RD_FETCH; rD SHALL be 0 outside RD_SHIFT.
REQ-025 A write followed by a read of the same address SHALL return the written word (no extra write-to-read latency beyond the header).
REQ-026 Bit counter width SHALL cover max(DATA_WIDTH, ADDR_WIDTH); no counter overflow in any state.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, ready=1, rD=0, bit counter=0, addr=0, from any state, including mid-header and mid-word.
REQ-028 Memory contents SHALL NOT be reset; a partial word in flight at reset SHALL NOT be written.
REQ-029 The first cycle after rst deasserts SHALL accept a start bit.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-030 Single write: start, R/W=1, addr 0011, wD 10100101 with valid=1, last on bit 8 -> mem[3]=0xA5, IDLE, ready=1.
REQ-031 Single read of addr 3 after REQ-030: ready=0 one cycle after final addr bit, then rD 1,0,1,0,0,1,0,1 over 8 valid cycles, last on bit 8 -> IDLE.
REQ-032 Wrapping burst write: addr 1111, words 0x11 then 0x22, last on bit 16 -> mem[15]=0x11, mem[0]=0x22.
REQ-033 Valid gaps: write 0x3C to addr 5 with valid=0 inserted after bits 2 and 6 -> mem[5]=0x3C; read with gaps -> rD held during gaps, same bit sequence.
REQ-034 Early last: write to addr 7 with last on bit 5 -> mem[7] unchanged, IDLE next cycle; next start bit accepted.
REQ-035 Reset mid-write after 4 data bits to addr 2 -> IDLE, ready=1, rD=0, mem[2] unchanged; subsequent read of addr 3 returns 0xA5.
